// File: rtl/risc16_pkg.sv
// Shared constants for the RISC_16 fetch front-end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package risc16_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

  // Opcode field position inside an instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef logic [INSTR_W-1:0] instr_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input instr_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/risc16_fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries, with flush and occupancy count.
// Latency: a push is visible at the head one cycle later; the head is combinational from storage.
// Backpressure: push is dropped only when full without a simultaneous pop; the caller's credit check prevents that.
// Ports: clk/rst (sync, active-high), flush_i, push_i/push_dat_i, pop_i, head_o, count_o, empty_o.
module risc16_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] store_q [DEPTH];
  logic [PW:0]  wr_ptr_q, rd_ptr_q;
  logic         full;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | pop_i);
  assign head_o  = store_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage has no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush_i) store_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/risc16_fetch_unit.sv
// Instruction fetch front-end: program memory, PC, credit-based prefetch into a FIFO, valid/ready to the core.
// Latency: first word valid two edges after fetch starts; then one word per cycle with instr_ready held.
// Backpressure: instr_ready low stalls the head; issue stops once buffered + in-flight words reach FIFO_DEPTH.
// Ports: clk/rst (sync, active-high); enable; prog_we/prog_addr/prog_data load port;
//        redirect_valid/redirect_pc branch restart; instr_ready in; instr_valid/instruction/instr_pc out;
//        pc (next fetch address) and halted status out.
module risc16_fetch_unit
  import risc16_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               halted_q, halted_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  rd_pc_q;
  logic [INSTR_W-1:0] rd_data_q;

  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [CNT_W-1:0]   occupancy;
  logic               issue, ret, ret_halt, pop;

  // Credit: a word in flight already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy = fifo_count + CNT_W'(inflight_q);
  assign issue     = enable & ~prog_we & ~halted_q & ~redirect_valid &
                     (occupancy < CNT_W'(FIFO_DEPTH));
  // A redirect discards the returning word and ignores the core's ready.
  assign ret       = inflight_q & ~redirect_valid;
  assign ret_halt  = ret & (rd_data_q == HALT_INSTR);
  assign pop       = ~fifo_empty & instr_ready & ~redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    halted_d   = halted_q;
    inflight_d = issue & ~ret_halt;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else if (ret_halt) begin
      // Anything issued past the HALT is dropped; restart point is just after it.
      halted_d = 1'b1;
      pc_d     = rd_pc_q + ADDR_W'(1);
    end else if (issue) begin
      pc_d     = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      halted_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      inflight_q <= inflight_d;
    end
  end

  // Program memory survives reset. Issue excludes prog_we, so read and write never collide.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
    if (issue) begin
      rd_data_q <= mem_q[pc_q];
      rd_pc_q   <= pc_q;
    end
  end

  risc16_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (ret),
    .push_dat_i ({rd_pc_q, rd_data_q}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  // Outputs read as zero whenever nothing is buffered.
  assign instr_valid = ~fifo_empty;
  assign instruction = instr_valid ? fifo_head[INSTR_W-1:0] : '0;
  assign instr_pc    = instr_valid ? fifo_head[ENTRY_W-1:INSTR_W] : '0;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_risc16_fetch_unit.sv
module tb_risc16_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [7:0]  instr_pc;
  logic [7:0]  pc;
  logic        halted;

  risc16_fetch_unit #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .pc             (pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, buffered words as a queue, one outstanding read.
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
  } entry_t;

  logic [15:0] m_mem [256];
  entry_t      m_q[$];
  logic [7:0]  m_pc;
  logic        m_halted;
  int          m_infl;
  logic [7:0]  m_rd_pc;
  logic [15:0] m_rd_data;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        vld;
    logic [15:0] ins;
    logic [7:0]  ipc;
    logic [7:0]  pc;
    logic        hlt;
  } vec_t;

  vec_t tbl[6];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic model_step();
    logic halt_ret;
    logic do_issue;
    if (rst) begin
      m_q.delete();
      m_pc     = 8'h00;
      m_halted = 1'b0;
      m_infl   = 0;
    end else begin
      do_issue = enable && !prog_we && !m_halted && !redirect_valid &&
                 ((m_q.size() + m_infl) < DEPTH);
      if (redirect_valid) begin
        m_q.delete();
        m_pc     = redirect_pc;
        m_halted = 1'b0;
        m_infl   = 0;
      end else begin
        if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
        halt_ret = 1'b0;
        if (m_infl != 0) begin
          m_q.push_back('{pc: m_rd_pc, data: m_rd_data});
          halt_ret = (m_rd_data == 16'hFFFF);
        end
        if (halt_ret) begin
          m_halted = 1'b1;
          m_pc     = m_rd_pc + 8'd1;
          m_infl   = 0;
        end else if (do_issue) begin
          m_rd_pc   = m_pc;
          m_rd_data = m_mem[m_pc];
          m_pc      = m_pc + 8'd1;
          m_infl    = 1;
        end else begin
          m_infl = 0;
        end
      end
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
  endtask

  task automatic model_check();
    logic        e_vld;
    logic [15:0] e_ins;
    logic [7:0]  e_ipc;
    e_vld = (m_q.size() > 0);
    e_ins = e_vld ? m_q[0].data : 16'h0;
    e_ipc = e_vld ? m_q[0].pc : 8'h0;
    chk("m_valid",  32'(instr_valid), 32'(e_vld));
    chk("m_instr",  32'(instruction), 32'(e_ins));
    chk("m_ipc",    32'(instr_pc),    32'(e_ipc));
    chk("m_pc",     32'(pc),          32'(m_pc));
    chk("m_halted", 32'(halted),      32'(m_halted));
  endtask

  // Inputs change only after the falling edge; outputs are compared there too.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Expect `want` consecutive deliveries starting at `first`, within `budget` cycles.
  task automatic collect(input int want, input logic [7:0] first, input int budget);
    int n;
    logic [7:0] e;
    n = 0;
    for (int c = 0; c < budget && n < want; c++) begin
      if (instr_valid && instr_ready) begin
        e = first + 8'(n);
        chk("deliv_pc",   32'(instr_pc),    32'(e));
        chk("deliv_data", 32'(instruction), 32'(m_mem[e]));
        n++;
      end
      tick();
    end
    chk("deliv_count", 32'(n), 32'(want));
  endtask

  initial begin
    int n;
    logic [15:0] w;

    // Program 0x1001, 0x1002, HALT then stream with instr_ready=1.
    tbl[0] = '{en:1'b1, rdy:1'b1, vld:1'b0, ins:16'h0000, ipc:8'h00, pc:8'h01, hlt:1'b0};
    tbl[1] = '{en:1'b1, rdy:1'b1, vld:1'b1, ins:16'h1001, ipc:8'h00, pc:8'h02, hlt:1'b0};
    tbl[2] = '{en:1'b1, rdy:1'b1, vld:1'b1, ins:16'h1002, ipc:8'h01, pc:8'h03, hlt:1'b0};
    tbl[3] = '{en:1'b1, rdy:1'b1, vld:1'b1, ins:16'hFFFF, ipc:8'h02, pc:8'h03, hlt:1'b1};
    tbl[4] = '{en:1'b1, rdy:1'b1, vld:1'b0, ins:16'h0000, ipc:8'h00, pc:8'h03, hlt:1'b1};
    tbl[5] = '{en:1'b1, rdy:1'b1, vld:1'b0, ins:16'h0000, ipc:8'h00, pc:8'h03, hlt:1'b1};

    rst = 1'b1; enable = 1'b0; prog_we = 1'b0; prog_addr = 8'h0; prog_data = 16'h0;
    redirect_valid = 1'b0; redirect_pc = 8'h0; instr_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_instr",  32'(instruction), 32'd0);
    chk("rst_ipc",    32'(instr_pc),    32'd0);
    chk("rst_pc",     32'(pc),          32'd0);
    chk("rst_halted", 32'(halted),      32'd0);

    // Fill the whole memory with non-HALT words while fetch is disabled.
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0123;
      prog_we = 1'b1; prog_addr = 8'(a); prog_data = w;
      tick();
    end

    // Test 1: load and stream until HALT.
    enable = 1'b1; instr_ready = 1'b1;
    prog_addr = 8'h00; prog_data = 16'h1001; tick();
    prog_addr = 8'h01; prog_data = 16'h1002; tick();
    prog_addr = 8'h02; prog_data = 16'hFFFF; tick();
    prog_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enable = tbl[i].en; instr_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_vld", i), 32'(instr_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_ins", i), 32'(instruction), 32'(tbl[i].ins));
      chk($sformatf("tbl%0d_ipc", i), 32'(instr_pc),    32'(tbl[i].ipc));
      chk($sformatf("tbl%0d_pc", i),  32'(pc),          32'(tbl[i].pc));
      chk($sformatf("tbl%0d_hlt", i), 32'(halted),      32'(tbl[i].hlt));
    end

    // Test 2: stall fills the FIFO with pcs 0..3, then drain without loss.
    enable = 1'b0;
    prog_we = 1'b1; prog_addr = 8'h02; prog_data = 16'h1003; tick();
    prog_we = 1'b0;
    do_reset();
    enable = 1'b1; instr_ready = 1'b0;
    repeat (8) tick();
    chk("t2_pc",    32'(pc),          32'h04);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_head",  32'(instr_pc),    32'h00);
    chk("t2_data",  32'(instruction), 32'h1001);
    instr_ready = 1'b1;
    collect(8, 8'h00, 20);

    // Test 3: redirect from a full FIFO.
    do_reset();
    instr_ready = 1'b0;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk("t3_valid0", 32'(instr_valid), 32'd0);
    chk("t3_pc",     32'(pc),          32'h10);
    tick();
    chk("t3_valid1", 32'(instr_valid), 32'd0);
    tick();
    chk("t3_valid2", 32'(instr_valid), 32'd1);
    chk("t3_ipc",    32'(instr_pc),    32'h10);
    chk("t3_instr",  32'(instruction), 32'(m_mem[8'h10]));

    // Test 4: redirect near the top of memory wraps to 0.
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    collect(4, 8'hFE, 20);

    // Test 5: reset with 3 buffered and one in flight.
    do_reset();
    instr_ready = 1'b0;
    repeat (4) tick();
    do_reset();
    chk("t5_valid",  32'(instr_valid), 32'd0);
    chk("t5_pc",     32'(pc),          32'd0);
    chk("t5_halted", 32'(halted),      32'd0);
    instr_ready = 1'b1;
    collect(4, 8'h00, 20);

    // Test 6: enable drops right after a single issue.
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (instr_valid && instr_ready) n++;
      tick();
    end
    chk("t6_count", 32'(n),  32'd1);
    chk("t6_pc",    32'(pc), 32'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      enable         = ($urandom_range(0, 9) < 8);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom);
      prog_we        = ($urandom_range(0, 29) == 0);
      prog_addr      = 8'($urandom);
      prog_data      = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
